// File: rtl/spgd_update.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spgd_update : two-sided SPGD control-update engine (u+p / u-p, J+ / J-)   |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module spgd_update #(
  parameter int FP_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic signed [FP_WIDTH-1:0] PERT_A,
  input  logic signed [FP_WIDTH-1:0] PERT_B,
  input  logic signed [FP_WIDTH-1:0] GAIN,
  input  logic signed [FP_WIDTH-1:0] J,
  input  logic                       J_valid,
  output logic                       meas_req,
  output logic signed [FP_WIDTH-1:0] U_A,
  output logic signed [FP_WIDTH-1:0] U_B,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                iter_cnt
);

  localparam int W = FP_WIDTH;
  localparam int F = FP_WIDTH / 2;
  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_APPLY_P = 3'd2;
  localparam logic [2:0] S_WAIT_P  = 3'd3;
  localparam logic [2:0] S_APPLY_M = 3'd4;
  localparam logic [2:0] S_WAIT_M  = 3'd5;
  localparam logic [2:0] S_CALC    = 3'd6;
  localparam logic [2:0] S_UPDATE  = 3'd7;

  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) sat_add = s[W] ? MIN_V : MAX_V;
    else                sat_add = s[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} - {b[W-1], b};
    if (s[W] != s[W-1]) sat_sub = s[W] ? MIN_V : MAX_V;
    else                sat_sub = s[W-1:0];
  endfunction

  // Q-format product: keep the middle W bits (floor); any disagreement in the
  // discarded high bits versus the kept sign bit means overflow.
  function automatic logic signed [W-1:0] sat_mul(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [2*W-1:0] prod;
    logic [W-F:0]          hi;
    prod = a * b;
    hi   = prod[2*W-1:W+F-1];
    if (!((&hi) || !(|hi))) sat_mul = prod[2*W-1] ? MIN_V : MAX_V;
    else                    sat_mul = prod[W+F-1:F];
  endfunction

  logic [2:0]          state_q, state_d;
  logic signed [W-1:0] u_q   [2];
  logic signed [W-1:0] u_d   [2];
  logic signed [W-1:0] p_q   [2];
  logic signed [W-1:0] p_d   [2];
  logic signed [W-1:0] uo_q  [2];
  logic signed [W-1:0] uo_d  [2];
  logic signed [W-1:0] pert  [2];
  logic signed [W-1:0] j_p_q, j_p_d;
  logic signed [W-1:0] j_m_q, j_m_d;
  logic signed [W-1:0] g_q, g_d;
  logic [31:0]         iter_cnt_q, iter_cnt_d;

  assign pert[0] = PERT_A;
  assign pert[1] = PERT_B;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (run) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_APPLY_P;
      S_APPLY_P: state_d = S_WAIT_P;
      S_WAIT_P:  if (J_valid) state_d = S_APPLY_M;
      S_APPLY_M: state_d = S_WAIT_M;
      S_WAIT_M:  if (J_valid) state_d = S_CALC;
      S_CALC:    state_d = S_UPDATE;
      S_UPDATE:  state_d = run ? S_CAPTURE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    meas_req = (state_q == S_APPLY_P) || (state_q == S_APPLY_M);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_UPDATE);
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      u_d[i]  = u_q[i];
      p_d[i]  = p_q[i];
      uo_d[i] = uo_q[i];
    end
    j_p_d      = j_p_q;
    j_m_d      = j_m_q;
    g_d        = g_q;
    iter_cnt_d = iter_cnt_q;
    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < 2; i++) uo_d[i] = u_q[i];
      end
      S_CAPTURE: begin
        // The fresh perturbation feeds the output directly so u+p appears in APPLY_P.
        for (int i = 0; i < 2; i++) begin
          p_d[i]  = pert[i];
          uo_d[i] = sat_add(u_q[i], pert[i]);
        end
      end
      S_WAIT_P: begin
        if (J_valid) begin
          j_p_d = J;
          for (int i = 0; i < 2; i++) uo_d[i] = sat_sub(u_q[i], p_q[i]);
        end
      end
      S_WAIT_M: begin
        if (J_valid) j_m_d = J;
      end
      S_CALC: begin
        g_d = sat_mul(GAIN, sat_sub(j_p_q, j_m_q));
        for (int i = 0; i < 2; i++) uo_d[i] = u_q[i];
      end
      S_UPDATE: begin
        for (int i = 0; i < 2; i++) begin
          u_d[i]  = sat_add(u_q[i], sat_mul(g_q, p_q[i]));
          uo_d[i] = u_d[i];
        end
        iter_cnt_d = iter_cnt_q + 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        u_q[i]  <= '0;
        p_q[i]  <= '0;
        uo_q[i] <= '0;
      end
      j_p_q      <= '0;
      j_m_q      <= '0;
      g_q        <= '0;
      iter_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        u_q[i]  <= u_d[i];
        p_q[i]  <= p_d[i];
        uo_q[i] <= uo_d[i];
      end
      j_p_q      <= j_p_d;
      j_m_q      <= j_m_d;
      g_q        <= g_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  assign U_A      = uo_q[0];
  assign U_B      = uo_q[1];
  assign iter_cnt = iter_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spgd_update.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spgd_update : scoreboard bench for spgd_update, directed vectors       |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_spgd_update;

  localparam logic [63:0] ONE   = 64'h0000_0001_0000_0000;
  localparam logic [63:0] NONE  = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] HALF  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] NHALF = 64'hFFFF_FFFF_8000_0000;
  localparam logic [63:0] TWO   = 64'h0000_0002_0000_0000;
  localparam logic [63:0] THREE = 64'h0000_0003_0000_0000;
  localparam logic [63:0] FOUR  = 64'h0000_0004_0000_0000;
  localparam logic [63:0] J99   = 64'h0000_0063_0000_0000;
  localparam logic [63:0] MAXV  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] BIG   = 64'h7FFF_FFFF_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [63:0] PERT_A = '0, PERT_B = '0, GAIN = '0, J = '0;
  logic        J_valid = 1'b0;
  logic        meas_req, busy, done;
  logic [63:0] U_A, U_B;
  logic [31:0] iter_cnt;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [31:0] cnt;
    bit          is_final;
  } exp_t;
  exp_t q[$];

  spgd_update #(.FP_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .run(run),
    .PERT_A(PERT_A), .PERT_B(PERT_B), .GAIN(GAIN), .J(J), .J_valid(J_valid),
    .meas_req(meas_req), .U_A(U_A), .U_B(U_B),
    .busy(busy), .done(done), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endfunction

  // Monitor: meas_req pulses and the cycle after done pop the next expectation.
  initial begin
    bit   done_seen;
    exp_t e;
    done_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (done_seen) begin
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_done: got done with empty scoreboard expected none");
        end else begin
          e = q.pop_front();
          if (!e.is_final) begin
            n_chk++; n_err++;
            $display("FAIL %s: got iteration end expected meas_req", e.name);
          end else begin
            chk({e.name, " U_A"}, U_A, e.ua);
            chk({e.name, " U_B"}, U_B, e.ub);
            chk({e.name, " iter_cnt"}, {32'd0, iter_cnt}, {32'd0, e.cnt});
          end
        end
      end
      done_seen = done;
      if (meas_req) begin
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_meas_req: got meas_req=1 expected 0");
        end else begin
          e = q.pop_front();
          if (e.is_final) begin
            n_chk++; n_err++;
            $display("FAIL %s: got meas_req expected iteration end", e.name);
          end else begin
            chk({e.name, " U_A"}, U_A, e.ua);
            chk({e.name, " U_B"}, U_B, e.ub);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_meas(input string nm);
    int n;
    n = 0;
    while (!meas_req && n < 20) begin
      tick();
      n++;
    end
    if (!meas_req) begin
      n_chk++; n_err++;
      $display("FAIL %s meas_req_wait: got timeout expected meas_req", nm);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; J_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic run_iter(input string nm,
                          input logic [63:0] pa, input logic [63:0] pb, input logic [63:0] gn,
                          input logic [63:0] jp, input logic [63:0] jm,
                          input logic [63:0] epa, input logic [63:0] epb,
                          input logic [63:0] ema, input logic [63:0] emb,
                          input logic [63:0] efa, input logic [63:0] efb,
                          input logic [31:0] ecnt, input bit stray, input bit hold_run);
    q.push_back('{{nm, " APPLY_P"}, epa, epb, 32'd0, 1'b0});
    q.push_back('{{nm, " APPLY_M"}, ema, emb, 32'd0, 1'b0});
    q.push_back('{{nm, " final"},   efa, efb, ecnt,  1'b1});
    PERT_A = pa; PERT_B = pb; GAIN = gn; run = 1'b1;
    tick();                                  // CAPTURE
    if (!hold_run) run = 1'b0;
    J_valid = stray; J = J99;
    tick();                                  // APPLY_P
    wait_meas(nm);
    J_valid = stray; J = J99;
    tick();                                  // WAIT_P
    J_valid = 1'b1; J = jp;
    tick();                                  // APPLY_M
    J_valid = 1'b0;
    wait_meas(nm);
    tick();                                  // WAIT_M
    J_valid = 1'b1; J = jm; run = 1'b0;
    tick();                                  // CALC
    J_valid = stray; J = J99;
    tick();                                  // UPDATE
    J_valid = 1'b0;
    tick(); tick();
    chk({nm, " busy_after"}, {63'd0, busy}, 64'd0);
    chk({nm, " meas_req_after"}, {63'd0, meas_req}, 64'd0);
  endtask

  initial begin
    // Reset held with run high and random inputs
    rst = 1'b0; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      PERT_A = {$urandom, $urandom}; PERT_B = {$urandom, $urandom};
      GAIN = {$urandom, $urandom}; J = {$urandom, $urandom}; J_valid = 1'b1;
      tick();
    end
    chk("rst U_A", U_A, 64'd0);
    chk("rst U_B", U_B, 64'd0);
    chk("rst meas_req", {63'd0, meas_req}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst iter_cnt", {32'd0, iter_cnt}, 64'd0);
    run = 1'b0; J_valid = 1'b0;
    rst = 1'b1;
    tick();

    // Single iteration, run pulsed
    run_iter("single", ONE, NHALF, HALF, THREE, ONE,
             ONE, NHALF, NONE, HALF, ONE, NHALF, 32'd1, 1'b0, 1'b0);

    // Stray J_valid in CAPTURE / APPLY_P / CALC
    do_reset();
    run_iter("stray", ONE, NHALF, HALF, THREE, ONE,
             ONE, NHALF, NONE, HALF, ONE, NHALF, 32'd1, 1'b1, 1'b0);

    // Saturation: build u_A up to 0x7FFF_FFFF_0000_0000, then push past it
    do_reset();
    run_iter("sat1", BIG, 64'd0, ONE, ONE, 64'd0,
             BIG, 64'd0, 64'h8000_0001_0000_0000, 64'd0, BIG, 64'd0, 32'd1, 1'b0, 1'b0);
    run_iter("sat2", TWO, 64'd0, 64'd0, 64'd0, 64'd0,
             MAXV, 64'd0, 64'h7FFF_FFFD_0000_0000, 64'd0, BIG, 64'd0, 32'd2, 1'b0, 1'b0);
    run_iter("sat3", TWO, NONE, 64'h4000_0000_0000_0000, FOUR, 64'd0,
             MAXV, NONE, 64'h7FFF_FFFD_0000_0000, ONE,
             MAXV, 64'h8000_0000_0000_0001, 32'd3, 1'b0, 1'b0);

    // run dropped in WAIT_M; negative product truncates toward -inf
    do_reset();
    run_iter("rundrop", ONE, 64'd1, HALF, ONE, TWO,
             ONE, 64'd1, NONE, 64'hFFFF_FFFF_FFFF_FFFF,
             NHALF, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 1'b0, 1'b1);

    // Asynchronous reset during WAIT_P
    q.push_back('{"rstwp APPLY_P", HALF, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b0});
    PERT_A = ONE; PERT_B = 64'd0; run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    wait_meas("rstwp");
    tick();                                  // WAIT_P
    #2 rst = 1'b0;
    #1;
    chk("rstwp U_A", U_A, 64'd0);
    chk("rstwp U_B", U_B, 64'd0);
    chk("rstwp busy", {63'd0, busy}, 64'd0);
    chk("rstwp iter_cnt", {32'd0, iter_cnt}, 64'd0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstwp idle busy", {63'd0, busy}, 64'd0);
    end

    chk("scoreboard drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spgd_update.md
# spgd_update

Two-sided SPGD control-update engine; consumes the Gaussian perturbation pair PERT_A/PERT_B produced by PRNG and closes the optimisation loop. Each iteration applies u+p, then u−p, to the actuator outputs, collects one metric sample per side, and updates u ← u + GAIN·(J+ − J−)·p. It sits between PRNG and the actuator/metric interface.

## Interface

- FP_WIDTH, 64, word width of all data; signed fixed point Q(FP_WIDTH/2).(FP_WIDTH/2)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; iterations run while high
- PERT_A, PERT_B  in  FP_WIDTH  signed perturbations from PRNG (free-running, new value every cycle)
- GAIN  in  FP_WIDTH  signed gain; sampled in CALC
- J  in  FP_WIDTH  signed metric sample
- J_valid  in  1  J qualifier
- meas_req  out  1  one-cycle pulse: actuators settled, measure metric
- U_A, U_B  out  FP_WIDTH  signed actuator commands (registered)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of each iteration
- iter_cnt  out  32  completed iterations, wraps 0xFFFF_FFFF → 0

## Operation

- State registers: u_A, u_B (base point), p_A, p_B, j_p, j_m, g.
- FSM states: IDLE, CAPTURE, APPLY_P, WAIT_P, APPLY_M, WAIT_M, CALC, UPDATE.
- IDLE: U = u; if run → CAPTURE.
- CAPTURE: p ← PERT; U ← sat(u+p) at exit; → APPLY_P.
- APPLY_P: meas_req=1; → WAIT_P.
- WAIT_P: on J_valid, j_p ← J, U ← sat(u−p); → APPLY_M. Else stay.
- APPLY_M: meas_req=1; → WAIT_M.
- WAIT_M: on J_valid, j_m ← J; → CALC.
- CALC: g ← sat(GAIN · sat(j_p − j_m)); U ← u.
- UPDATE: u ← sat(u + sat(g·p)) per channel; U ← new u; done=1; iter_cnt++; → CAPTURE if run else IDLE.
- Multiply: full 2·FP_WIDTH signed product, take bits [FP_WIDTH+FP_WIDTH/2−1 : FP_WIDTH/2] (truncate toward −∞), saturate on overflow.
- sat(): clamp to 0x7FFF…F / 0x8000…0; applies to every add, subtract, and product.
- J_valid outside WAIT_P/WAIT_M is ignored; no buffering.
- run deasserted mid-iteration: iteration completes, including the update, then → IDLE.
- rst low at any time: FSM → IDLE, all registers 0.

## Timing

- Reset values: U_A=U_B=0, meas_req=0, busy=0, done=0, iter_cnt=0, u=p=j_p=j_m=g=0.
- run sampled in IDLE; CAPTURE is the next cycle.
- U = u+p is valid in the first cycle of APPLY_P, the same cycle meas_req is high.
- U = u−p is valid in the first cycle of APPLY_M.
- J_valid is accepted at the earliest in the cycle after meas_req, i.e. the first WAIT cycle.
- Minimum iteration with J_valid in the first WAIT cycle: 7 cycles (CAPTURE…UPDATE). Back-to-back period: 7 cycles.
- Updated U and iter_cnt are visible the cycle after done.

## Test plan

- Reset: hold rst=0 with run=1 and random inputs → U_A=U_B=0, meas_req=0, busy=0, iter_cnt=0.
- Single iteration, run pulsed 1 cycle:
  - Inputs: PERT_A=0x0000_0001_0000_0000 (1.0), PERT_B=0xFFFF_FFFF_8000_0000 (−0.5), GAIN=0x0000_0000_8000_0000 (0.5), J+=3.0, J−=1.0.
  - APPLY_P: U_A=1.0, U_B=−0.5.
  - APPLY_M: U_A=−1.0, U_B=0.5.
  - Final: U_A=1.0, U_B=−0.5; done pulses once; iter_cnt=1; IDLE.
- Saturation:
  - Setup: u_A=0x7FFF_FFFF_0000_0000 (after prior iterations), PERT_A=2.0.
  - Required: U_A=0x7FFF_FFFF_FFFF_FFFF in APPLY_P, no wrap.
- Stray J_valid: J_valid pulses during CAPTURE/APPLY_P/CALC with J=99.0 → ignored; j_p/j_m take only the WAIT-state samples; update matches the single-iteration values.
- run deasserted during WAIT_M → iteration completes (done=1, iter_cnt increments), then busy=0, no new meas_req.
- rst asserted during WAIT_P → U=0, busy=0 immediately (asynchronous). After release with run=0, the block stays in IDLE.
